// File: rtl/shift_accumulator.sv
// shift_accumulator: multi-lane shift-and-accumulate stage.
// Each lane sign-extends a signed operand, shifts it left by a per-beat amount
// and sums the shifted terms over a first..last group. The group total is
// converted to the output width (clamped or truncated) and held in a single
// output register behind a valid/ready handshake.
module shift_accumulator #(
    parameter int NUM_LANES    = 4,
    parameter int IN_WIDTH     = 8,
    parameter int OUT_WIDTH    = 16,
    parameter int ACC_WIDTH    = OUT_WIDTH + 8,
    parameter int SHIFT_WIDTH  = $clog2(OUT_WIDTH),
    parameter int SHIFT_AMOUNT = 1,
    parameter int SATURATE     = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_LANES*IN_WIDTH-1:0]  in_data,
    input  logic [SHIFT_WIDTH-1:0]         in_shift,
    input  logic                           in_first,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES*OUT_WIDTH-1:0] out_data,
    output logic [NUM_LANES-1:0]           out_overflow
);

    // Largest and smallest values representable in the output width.
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    // Bits of the accumulator that must all equal the sign bit for the
    // value to fit in OUT_WIDTH.
    localparam int HI_WIDTH = ACC_WIDTH - OUT_WIDTH + 1;

    logic signed [ACC_WIDTH-1:0] acc      [NUM_LANES];
    logic                        wrap     [NUM_LANES];

    logic signed [ACC_WIDTH-1:0] term     [NUM_LANES];
    logic signed [ACC_WIDTH-1:0] base     [NUM_LANES];
    logic signed [ACC_WIDTH-1:0] sum      [NUM_LANES];
    logic                        wrap_nxt [NUM_LANES];
    logic [HI_WIDTH-1:0]         hi       [NUM_LANES];
    logic [OUT_WIDTH-1:0]        res      [NUM_LANES];
    logic                        res_ovf  [NUM_LANES];
    int                          shamt;
    logic                        accept;

    // One output register: a new beat fits whenever it is empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Per-lane term, running sum, wrap tracking and output conversion.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        shamt = int'(in_shift) * SHIFT_AMOUNT;
        for (int l = 0; l < NUM_LANES; l++) begin
            term[l]     = ACC_WIDTH'(signed'(in_data[l*IN_WIDTH +: IN_WIDTH])) <<< shamt;
            base[l]     = in_first ? '0 : acc[l];
            sum[l]      = base[l] + term[l];
            // Signed add overflow: operands share a sign the result does not.
            wrap_nxt[l] = (!in_first && wrap[l]) ||
                          (!in_first &&
                           (acc[l][ACC_WIDTH-1] == term[l][ACC_WIDTH-1]) &&
                           (sum[l][ACC_WIDTH-1] != acc[l][ACC_WIDTH-1]));
            hi[l]       = sum[l][ACC_WIDTH-1:OUT_WIDTH-1];
            res[l]      = sum[l][OUT_WIDTH-1:0];
            res_ovf[l]  = wrap_nxt[l];
            if (!((&hi[l]) || (~|hi[l]))) begin
                res_ovf[l] = 1'b1;
                if (SATURATE != 0) begin
                    res[l] = sum[l][ACC_WIDTH-1] ? OUT_MIN : OUT_MAX;
                end
            end
        end
    end

    // Accumulator, wrap flags and output register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                acc[l]  <= '0;
                wrap[l] <= 1'b0;
            end
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_overflow <= '0;
        end else begin
            if (accept) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    acc[l]  <= in_last ? '0 : sum[l];
                    wrap[l] <= in_last ? 1'b0 : wrap_nxt[l];
                end
            end
            if (accept && in_last) begin
                out_valid <= 1'b1;
                for (int l = 0; l < NUM_LANES; l++) begin
                    out_data[l*OUT_WIDTH +: OUT_WIDTH] <= res[l];
                    out_overflow[l]                    <= res_ovf[l];
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_accumulator.sv
// tb_shift_accumulator: directed cases plus randomized traffic checked
// against an arithmetic reference model and a result scoreboard.
module tb_shift_accumulator;

    localparam int NL = 4;
    localparam int IW = 8;
    localparam int OW = 16;
    localparam int SW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [NL*IW-1:0]  in_data;
    logic [SW-1:0]     in_shift;
    logic              in_first;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [NL*OW-1:0]  out_data;
    logic [NL-1:0]     out_overflow;

    shift_accumulator dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_shift     (in_shift),
        .in_first     (in_first),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NL*OW-1:0] d;
        logic [NL-1:0]    o;
    } result_t;

    int      n_checks = 0;
    int      n_errors = 0;
    result_t exp_q[$];
    longint  m_acc  [NL];
    bit      m_wrap [NL];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reduce an integer to the signed 24-bit accumulator range.
    function automatic longint wrap24(input longint x);
        longint t;
        t = x & 64'hFF_FFFF;
        if (t >= 64'sd8388608) t = t - 64'sd16777216;
        return t;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int l = 0; l < NL; l++) begin
            m_acc[l]  = 0;
            m_wrap[l] = 0;
        end
    endtask

    // Apply one accepted beat to the model; queue a result on last.
    task automatic model_beat();
        result_t r;
        longint  v, t, exact;
        r.d = '0;
        r.o = '0;
        for (int l = 0; l < NL; l++) begin
            v = longint'($signed(in_data[l*IW +: IW]));
            t = wrap24(v * (longint'(1) << in_shift));
            if (in_first) begin
                m_acc[l]  = t;
                m_wrap[l] = 0;
            end else begin
                exact = m_acc[l] + t;
                if (exact > 64'sd8388607 || exact < -64'sd8388608) m_wrap[l] = 1;
                m_acc[l] = wrap24(exact);
            end
            if (in_last) begin
                if (m_acc[l] > 32767) begin
                    r.d[l*OW +: OW] = 16'h7FFF;
                    r.o[l]          = 1'b1;
                end else if (m_acc[l] < -32768) begin
                    r.d[l*OW +: OW] = 16'h8000;
                    r.o[l]          = 1'b1;
                end else begin
                    r.d[l*OW +: OW] = 16'(m_acc[l]);
                    r.o[l]          = m_wrap[l];
                end
                m_acc[l]  = 0;
                m_wrap[l] = 0;
            end
        end
        if (in_last) exp_q.push_back(r);
    endtask

    // One clock: check handshake and output at the falling edge, update
    // the model, then return just after the next rising edge.
    task automatic step();
        bit exp_ready;
        @(negedge clk);
        if (reset) begin
            model_reset();
        end else begin
            exp_ready = (exp_q.size() == 0) || out_ready;
            check("in_ready", 64'(in_ready), 64'(exp_ready));
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0 && out_valid) begin
                check("out_data", 64'(out_data), 64'(exp_q[0].d));
                check("out_overflow", 64'(out_overflow), 64'(exp_q[0].o));
            end
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (in_valid && exp_ready) model_beat();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit f, input bit l, input logic [SW-1:0] sh,
                         input int l0, input int l1, input int l2, input int l3);
        in_valid = v;
        in_first = f;
        in_last  = l;
        in_shift = sh;
        in_data  = {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endtask

    logic [NL*OW-1:0] snap;

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) step();
        reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_overflow", 64'(out_overflow), 64'd0);

        // Single-beat group with shift 2.
        out_ready = 1'b1;
        drive(1, 1, 1, 2, -3, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("t1_lane0", 64'(out_data[15:0]), 64'hFFF4);
        check("t1_ovf", 64'(out_overflow), 64'd0);
        step();

        // Two-beat group: 5 + (3<<4) and -1 + (-1<<4).
        drive(1, 1, 0, 0, 5, -1, -1, -1);
        step();
        drive(1, 0, 1, 4, 3, -1, -1, -1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("t2_lane0", 64'(out_data[15:0]), 64'd53);
        check("t2_lane3", 64'(out_data[63:48]), 64'hFFEF);
        step();

        // Saturation in both directions.
        drive(1, 1, 0, 15, 127, -128, 0, 0);
        step();
        drive(1, 0, 1, 15, 127, -128, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("t3_pos_sat", 64'(out_data[15:0]), 64'h7FFF);
        check("t3_neg_sat", 64'(out_data[31:16]), 64'h8000);
        check("t3_ovf", 64'(out_overflow), 64'b0011);
        step();

        // Backpressure: pending result blocks a new group until popped.
        out_ready = 1'b0;
        drive(1, 1, 1, 0, 1, 2, 3, 4);
        step();
        drive(1, 1, 1, 0, 9, 9, 9, 9);
        snap = out_data;
        repeat (5) begin
            step();
            check("t4_hold", 64'(out_data), 64'(snap));
            check("t4_blocked", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("t4_ready", 64'(in_ready), 64'd1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("t4_new", 64'(out_data[15:0]), 64'd9);
        step();

        // Reset mid-group discards the partial sum.
        drive(1, 1, 0, 0, 10, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        check("t5_valid_in_rst", 64'(out_valid), 64'd0);
        reset = 1'b0;
        drive(1, 0, 1, 0, 7, 0, 0, 0);
        check("t5_valid_after_rst", 64'(out_valid), 64'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("t5_lane0", 64'(out_data[15:0]), 64'd7);
        step();

        // Back-to-back single-beat groups, one result per cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1, SW'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)));
            step();
            check("t6_stream", 64'(out_valid), 64'd1);
        end

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) < 3, SW'($urandom_range(0, 15)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            step();
        end

        // Drain.
        out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
